// File: rtl/spi_sb_ctrl.sv
// spi_sb_ctrl: system-bus sequencer for the iCE40 hard SPI block.
// It configures the core once, then loops polling SPISR. A pending host
// byte is forwarded as cmd_valid/cmd_data. A pending measurement frame
// (header + 3 data bytes) is written to TXDR one byte per poll.
module spi_sb_ctrl #(
  parameter logic [3:0] SPI_BASE    = 4'h0,
  parameter logic [7:0] CR0_VAL     = 8'h00,
  parameter logic [7:0] CR1_VAL     = 8'h80,
  parameter logic [7:0] CR2_VAL     = 8'h00,
  parameter logic [7:0] BR_VAL      = 8'h00,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        rst,
  output logic        sb_stb_o,
  output logic        sb_wr_o,
  output logic [7:0]  sb_adr_o,
  output logic [7:0]  sb_dat_o,
  input  logic [7:0]  sb_dat_i,
  input  logic        sb_ack_i,
  input  logic        meas_valid,
  input  logic [23:0] meas_data,
  output logic        meas_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_data,
  output logic        tx_busy,
  output logic        init_done,
  output logic        bus_err
);

  localparam logic [3:0] OFF_CR0  = 4'h8;
  localparam logic [3:0] OFF_CR1  = 4'h9;
  localparam logic [3:0] OFF_CR2  = 4'hA;
  localparam logic [3:0] OFF_BR   = 4'hB;
  localparam logic [3:0] OFF_SR   = 4'hC;
  localparam logic [3:0] OFF_TXDR = 4'hD;
  localparam logic [3:0] OFF_RXDR = 4'hE;

  localparam int          TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {INIT_WR, POLL_RD, DECIDE, RX_RD, TX_WR, GAP} state_t;

  typedef struct packed {
    logic       wr;
    logic [3:0] off;
    logic [7:0] dat;
  } sb_req_t;

  state_t          state;
  logic [1:0]      init_idx;
  logic [1:0]      idx;
  logic [3:0][7:0] frame;
  logic [TW-1:0]   tmo_cnt;
  logic            st_rrdy;
  logic            st_trdy;
  logic            tx_ok;
  sb_req_t         req;

  // A frame only becomes eligible for TX once a poll has completed after capture.
  assign meas_ready = init_done & ~tx_busy & ~rst;

  // Next bus request for the current state; enable goes last in the init order.
  always_comb begin
    req = '{wr: 1'b0, off: OFF_SR, dat: 8'h00};
    case (state)
      INIT_WR: begin
        req.wr = 1'b1;
        case (init_idx)
          2'd0:    begin req.off = OFF_CR2; req.dat = CR2_VAL; end
          2'd1:    begin req.off = OFF_BR;  req.dat = BR_VAL;  end
          2'd2:    begin req.off = OFF_CR0; req.dat = CR0_VAL; end
          default: begin req.off = OFF_CR1; req.dat = CR1_VAL; end
        endcase
      end
      RX_RD: req.off = OFF_RXDR;
      TX_WR: begin
        req.wr  = 1'b1;
        req.off = OFF_TXDR;
        req.dat = frame[idx];
      end
      default: ;
    endcase
  end

  // Sequencer FSM, bus handshake, ack timeout and frame buffer.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= INIT_WR;
      init_idx  <= 2'd0;
      idx       <= 2'd0;
      frame     <= '0;
      tmo_cnt   <= '0;
      st_rrdy   <= 1'b0;
      st_trdy   <= 1'b0;
      tx_ok     <= 1'b0;
      sb_stb_o  <= 1'b0;
      sb_wr_o   <= 1'b0;
      sb_adr_o  <= 8'h00;
      sb_dat_o  <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_data  <= 8'h00;
      tx_busy   <= 1'b0;
      init_done <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;

      if (meas_valid && meas_ready) begin
        frame[0] <= HEADER;
        frame[1] <= meas_data[23:16];
        frame[2] <= meas_data[15:8];
        frame[3] <= meas_data[7:0];
        idx      <= 2'd0;
        tx_busy  <= 1'b1;
      end

      if (sb_stb_o) begin
        if (sb_ack_i) begin
          sb_stb_o <= 1'b0;
          tmo_cnt  <= '0;
          case (state)
            INIT_WR: begin
              if (init_idx == 2'd3) begin
                init_done <= 1'b1;
                init_idx  <= 2'd0;
                state     <= POLL_RD;
              end else begin
                init_idx <= init_idx + 2'd1;
              end
            end
            POLL_RD: begin
              st_rrdy <= sb_dat_i[3];
              st_trdy <= sb_dat_i[4];
              tx_ok   <= tx_busy;
              state   <= DECIDE;
            end
            RX_RD: begin
              cmd_data  <= sb_dat_i;
              cmd_valid <= 1'b1;
              state     <= GAP;
            end
            TX_WR: begin
              idx <= idx + 2'd1;
              if (idx == 2'd3) tx_busy <= 1'b0;
              state <= GAP;
            end
            default: state <= GAP;
          endcase
        end else if (tmo_cnt == TMO_LAST) begin
          // Abandon the cycle; a failed TXDR write keeps idx so the byte is retried.
          sb_stb_o <= 1'b0;
          tmo_cnt  <= '0;
          bus_err  <= 1'b1;
          if (state == INIT_WR) init_idx <= 2'd0;
          else                  state    <= POLL_RD;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        case (state)
          INIT_WR, POLL_RD, RX_RD, TX_WR: begin
            sb_stb_o <= 1'b1;
            sb_wr_o  <= req.wr;
            sb_adr_o <= {SPI_BASE, req.off};
            sb_dat_o <= req.dat;
            tmo_cnt  <= '0;
          end
          DECIDE: begin
            if (st_rrdy)                          state <= RX_RD;
            else if (st_trdy && tx_ok && tx_busy) state <= TX_WR;
            else                                  state <= GAP;
          end
          default: state <= POLL_RD;
        endcase
      end
    end
  end

endmodule
